rv_dbg_bridge: RTL and testbench

//  Serial debug/loader bridge: the bus-initiator end of the d-bus that peripherals like rv_sio answer.

---
 rtl/rv_dbg_bridge_pkg.sv | 12 +
 rtl/rv_dbg_uart.sv | 90 +++++++++
 rtl/rv_dbg_bridge.sv | 133 +++++++++++++
 tb/tb_rv_dbg_bridge.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_dbg_bridge_pkg.sv
// rv_dbg_bridge_pkg: debug bridge command opcodes and reply byte codes
package rv_dbg_bridge_pkg;
  typedef enum logic [7:0] {
    CMD_H = 8'h48,
    CMD_G = 8'h47,
    CMD_W = 8'h57,
    CMD_R = 8'h52
  } dbg_cmd_t;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_BAD = 8'h3F;
endpackage

// File: rtl/rv_dbg_uart.sv
// rv_dbg_uart: rxd synchroniser plus 8N1 byte receiver and back-to-back capable transmitter
module rv_dbg_uart
  import rv_dbg_bridge_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       xreset,
  input  logic       rxd,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       txd,
  output logic       tx_busy,
  output logic       tx_act
);
  localparam logic [15:0] FULL = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
  logic        s1, s2, s3, rx_act, tx_last, ld;
  logic [15:0] rx_cnt, tx_cnt;
  logic [3:0]  rx_bit, tx_bit;
  logic [7:0]  tx_sh;
  assign tx_last = tx_bit == 4'd9 && tx_cnt == 16'd0;
  assign tx_busy = tx_act && !(tx_bit == 4'd9 && tx_cnt <= 16'd1);
  assign ld      = tx_start && (!tx_act || tx_last);
  always_ff @(posedge clk) begin
    if (!xreset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end
  always_ff @(posedge clk) begin
    if (!xreset) begin
      rx_act   <= 1'b0;
      rx_valid <= 1'b0;
      rx_cnt   <= 16'd0;
      rx_bit   <= 4'd0;
      rx_data  <= 8'd0;
    end else begin
      rx_valid <= 1'b0;
      if (!rx_act) begin
        if (s3 && !s2) begin
          rx_act <= 1'b1;
          rx_cnt <= HALF;
          rx_bit <= 4'd0;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= FULL;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) rx_act <= !s2;
        else if (rx_bit < 4'd9) rx_data <= {s2, rx_data[7:1]};
        else begin
          rx_act   <= 1'b0;
          rx_valid <= s2;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!xreset) begin
      txd    <= 1'b1;
      tx_act <= 1'b0;
      tx_cnt <= 16'd0;
      tx_bit <= 4'd0;
      tx_sh  <= 8'd0;
    end else if (ld) begin
      txd    <= 1'b0;
      tx_act <= 1'b1;
      tx_cnt <= FULL;
      tx_bit <= 4'd0;
      tx_sh  <= tx_data;
    end else if (tx_act) begin
      if (tx_cnt != 16'd0) tx_cnt <= tx_cnt - 16'd1;
      else begin
        tx_cnt <= FULL;
        tx_bit <= tx_bit + 4'd1;
        txd    <= tx_bit < 4'd8 ? tx_sh[tx_bit[2:0]] : 1'b1;
        tx_act <= tx_bit != 4'd9;
      end
    end
  end
endmodule

// File: rtl/rv_dbg_bridge.sv
// rv_dbg_bridge: serial command decoder that halts the core and runs single-word d-bus cycles
module rv_dbg_bridge
  import rv_dbg_bridge_pkg::*;
#(
  parameter int BAUD_DIV = 868,
  parameter int TMO      = 2000000
) (
  input  logic        clk,
  input  logic        xreset,
  input  logic        rxd,
  output logic        txd,
  output logic        hold,
  output logic [31:0] adr,
  output logic [31:0] dw,
  output logic [3:0]  we,
  output logic        re,
  input  logic        rdy,
  input  logic [31:0] dr,
  output logic        busy
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ADDR   = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] BUS    = 3'd3;
  localparam logic [2:0] BWAIT  = 3'd4;
  localparam logic [2:0] REPLY  = 3'd5;
  localparam logic [2:0] TXWAIT = 3'd6;
  logic [2:0]  state;
  logic [1:0]  cnt, rsp_n;
  logic [7:0]  opc, rx_data;
  logic [31:0] a, a_n, rsp, tmo;
  logic [23:0] d;
  logic        rx_valid, tx_busy, tx_act, tmo_hit;
  assign a_n     = {a[23:0], rx_data};
  assign tmo_hit = tmo == 32'(TMO - 1);
  assign busy    = state != IDLE || tx_act;
  rv_dbg_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk      (clk),
    .xreset   (xreset),
    .rxd      (rxd),
    .tx_data  (rsp[31:24]),
    .tx_start (state == REPLY),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .tx_act   (tx_act)
  );
  always_ff @(posedge clk) begin
    if (!xreset) begin
      state <= IDLE;
      cnt   <= 2'd0;
      rsp_n <= 2'd0;
      opc   <= 8'd0;
      a     <= 32'd0;
      d     <= 24'd0;
      rsp   <= 32'd0;
      tmo   <= 32'd0;
      hold  <= 1'b0;
      adr   <= 32'd0;
      dw    <= 32'd0;
      we    <= 4'h0;
      re    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (rx_valid) begin
          opc   <= rx_data;
          cnt   <= 2'd0;
          tmo   <= 32'd0;
          rsp_n <= 2'd0;
          rsp   <= {(rx_data == CMD_H || rx_data == CMD_G) ? RSP_OK : RSP_BAD, 24'h0};
          if (rx_data == CMD_H) hold <= 1'b1;
          if (rx_data == CMD_G) hold <= 1'b0;
          state <= (rx_data == CMD_W || rx_data == CMD_R) ? ADDR : REPLY;
        end
        ADDR: if (rx_valid) begin
          a   <= a_n;
          cnt <= cnt + 2'd1;
          tmo <= 32'd0;
          if (cnt == 2'd3) begin
            if (opc == CMD_W) state <= DATA;
            else if (hold) begin
              adr   <= {a_n[31:2], 2'b00};
              re    <= 1'b1;
              state <= BUS;
            end else begin
              rsp   <= {RSP_ERR, 24'h0};
              state <= REPLY;
            end
          end
        end else if (tmo_hit) state <= IDLE;
        else tmo <= tmo + 32'd1;
        DATA: if (rx_valid) begin
          d   <= {d[15:0], rx_data};
          cnt <= cnt + 2'd1;
          tmo <= 32'd0;
          if (cnt == 2'd3) begin
            if (hold) begin
              adr   <= {a[31:2], 2'b00};
              dw    <= {d, rx_data};
              we    <= 4'hf;
              state <= BUS;
            end else begin
              rsp   <= {RSP_ERR, 24'h0};
              state <= REPLY;
            end
          end
        end else if (tmo_hit) state <= IDLE;
        else tmo <= tmo + 32'd1;
        BUS: if (rdy) begin
          re    <= 1'b0;
          we    <= 4'h0;
          rsp   <= {RSP_OK, 24'h0};
          state <= re ? BWAIT : REPLY;
        end
        BWAIT: begin
          rsp   <= dr;
          rsp_n <= 2'd3;
          state <= REPLY;
        end
        REPLY: begin
          rsp   <= {rsp[23:0], 8'h0};
          state <= TXWAIT;
        end
        TXWAIT: if (!tx_busy) begin
          rsp_n <= rsp_n - 2'd1;
          state <= rsp_n == 2'd0 ? IDLE : REPLY;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_dbg_bridge.sv
// tb_rv_dbg_bridge: scoreboarded serial-command bench for the debug bridge with a bus memory model
module tb_rv_dbg_bridge;
  localparam int BD = 4;
  logic        clk = 1'b0, xreset = 1'b0, rxd = 1'b1;
  logic        txd, hold, re, rdy, busy;
  logic [31:0] adr, dw;
  logic [31:0] dr = 32'h0;
  logic [3:0]  we;
  int tests = 0, fails = 0, cyc = 0;
  int stall_len = 0, stall_cnt = 0;
  int wr_cnt = 0, rd_cnt = 0, we_cyc = 0, re_cyc = 0;
  logic [31:0] wr_adr = 32'h0, wr_dat = 32'h0, rd_adr = 32'h0;
  logic [31:0] mem [0:255];
  bit ignore_tx = 1'b0;
  logic [7:0] exp_q[$];
  int st_q[$];
  logic [7:0] mon_b, mon_e;
  logic mon_sb;
  int mon_t;

  rv_dbg_bridge #(.BAUD_DIV(BD), .TMO(200)) dut (
    .clk(clk), .xreset(xreset), .rxd(rxd), .txd(txd), .hold(hold), .adr(adr), .dw(dw),
    .we(we), .re(re), .rdy(rdy), .dr(dr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign rdy = stall_cnt >= stall_len;

  always @(posedge clk) begin
    stall_cnt <= (we != 4'h0 || re) ? stall_cnt + 1 : 0;
    if (we != 4'h0) we_cyc <= we_cyc + 1;
    if (re) re_cyc <= re_cyc + 1;
    if (we != 4'h0 && rdy) begin
      wr_cnt <= wr_cnt + 1;
      wr_adr <= adr;
      wr_dat <= dw;
      mem[adr[9:2]] <= dw;
    end
    if (re && rdy) begin
      rd_cnt <= rd_cnt + 1;
      rd_adr <= adr;
      dr <= mem[adr[9:2]];
    end
  end

  initial forever begin
    @(negedge txd);
    mon_t = cyc;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BD) @(negedge clk);
      mon_b[i] = txd;
    end
    repeat (BD) @(negedge clk);
    mon_sb = txd;
    if (!ignore_tx) begin
      st_q.push_back(mon_t);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: got byte %h, expected no reply", mon_b);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_b !== mon_e || mon_sb !== 1'b1) begin
          fails++;
          $display("FAIL tx_byte: got %h stop %b, expected %h stop 1", mon_b, mon_sb, mon_e);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BD) @(negedge clk);
    end
    rxd = stop;
    repeat (BD) @(negedge clk);
    rxd = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [71:0] v, input int n);
    for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    xreset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({txd, hold, re, busy} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_ctrl: txd/hold/re/busy=%b, expected 1000", {txd, hold, re, busy});
    end
    tests++;
    if ({we, adr, dw} !== 68'h0) begin
      fails++;
      $display("FAIL reset_bus: we=%h adr=%h dw=%h, expected all zero", we, adr, dw);
    end
    xreset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_go();
    bit ok;
    exp_q.push_back(8'h4B);
    send_bytes(72'h48, 1);
    tests++;
    if (hold !== 1'b1) begin
      fails++;
      $display("FAIL hold_set: hold=%b, expected 1", hold);
    end
    wait_idle(ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL h_reply: idle=%0d pending=%0d, expected idle=1 pending=0", ok, exp_q.size());
    end
    exp_q.push_back(8'h4B);
    send_bytes(72'h47, 1);
    tests++;
    if (hold !== 1'b0) begin
      fails++;
      $display("FAIL hold_clear: hold=%b, expected 0", hold);
    end
    wait_idle(ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL g_reply: idle=%0d pending=%0d, expected idle=1 pending=0", ok, exp_q.size());
    end
  endtask

  task automatic test_write();
    bit ok;
    int w0, c0;
    exp_q.push_back(8'h4B);
    send_bytes(72'h48, 1);
    wait_idle(ok);
    w0 = wr_cnt;
    c0 = we_cyc;
    exp_q.push_back(8'h4B);
    send_bytes(72'h57_00001000_DEADBEEF, 9);
    wait_idle(ok);
    tests++;
    if (wr_cnt - w0 != 1 || we_cyc - c0 != 1) begin
      fails++;
      $display("FAIL write_count: writes=%0d we_cycles=%0d, expected 1 and 1", wr_cnt - w0, we_cyc - c0);
    end
    tests++;
    if (wr_adr !== 32'h1000 || wr_dat !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL write_data: adr=%h dw=%h, expected 00001000 deadbeef", wr_adr, wr_dat);
    end
    tests++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL write_reply: idle=%0d pending=%0d, expected idle=1 pending=0", ok, exp_q.size());
    end
  endtask

  task automatic test_read();
    bit ok;
    int r0, e0, bad;
    r0 = rd_cnt;
    e0 = re_cyc;
    bad = 0;
    st_q.delete();
    exp_q.push_back(8'hDE);
    exp_q.push_back(8'hAD);
    exp_q.push_back(8'hBE);
    exp_q.push_back(8'hEF);
    send_bytes(72'h52_00001000, 5);
    wait_idle(ok);
    tests++;
    if (rd_cnt - r0 != 1 || re_cyc - e0 != 1 || rd_adr !== 32'h1000) begin
      fails++;
      $display("FAIL read_bus: reads=%0d re_cycles=%0d adr=%h, expected 1 1 00001000", rd_cnt - r0, re_cyc - e0, rd_adr);
    end
    tests++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL read_reply: idle=%0d pending=%0d, expected idle=1 pending=0", ok, exp_q.size());
    end
    for (int i = 1; i < st_q.size(); i++) if (st_q[i] - st_q[i-1] != 10 * BD) bad++;
    tests++;
    if (st_q.size() != 4 || bad != 0) begin
      fails++;
      $display("FAIL read_b2b: bytes=%0d gaps_off=%0d, expected 4 bytes 0 gaps_off", st_q.size(), bad);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int w0, c0, bad;
    w0 = wr_cnt;
    c0 = we_cyc;
    bad = 0;
    stall_len = 5;
    exp_q.push_back(8'h4B);
    send_bytes(72'h57_00001000_DEADBEEF, 9);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (we != 4'h0 && (we !== 4'hf || adr !== 32'h1000 || dw !== 32'hDEADBEEF)) bad++;
    end
    wait_idle(ok);
    stall_len = 0;
    tests++;
    if (we_cyc - c0 != 6 || wr_cnt - w0 != 1) begin
      fails++;
      $display("FAIL stall_count: we_cycles=%0d writes=%0d, expected 6 and 1", we_cyc - c0, wr_cnt - w0);
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_stable: unstable_cycles=%0d, expected 0", bad);
    end
    tests++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL stall_reply: idle=%0d pending=%0d, expected idle=1 pending=0", ok, exp_q.size());
    end
  endtask

  task automatic test_errors();
    bit ok;
    int r0, e0;
    exp_q.push_back(8'h4B);
    send_bytes(72'h47, 1);
    wait_idle(ok);
    r0 = rd_cnt;
    e0 = re_cyc;
    exp_q.push_back(8'h45);
    send_bytes(72'h52_00001000, 5);
    wait_idle(ok);
    tests++;
    if (rd_cnt != r0 || re_cyc != e0 || !ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL read_nohold: reads=%0d re_cycles=%0d pending=%0d, expected 0 0 0", rd_cnt - r0, re_cyc - e0, exp_q.size());
    end
    exp_q.push_back(8'h3F);
    send_bytes(72'h55, 1);
    wait_idle(ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bad_opcode: idle=%0d pending=%0d, expected idle=1 pending=0", ok, exp_q.size());
    end
    send_byte(8'h48, 1'b0);
    wait_idle(ok);
    repeat (50) @(negedge clk);
    tests++;
    if (hold !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL framing: hold=%b busy=%b, expected 0 0", hold, busy);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int w0;
    exp_q.push_back(8'h4B);
    send_bytes(72'h48, 1);
    wait_idle(ok);
    w0 = wr_cnt;
    send_bytes(72'h5700, 2);
    repeat (230) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || wr_cnt != w0) begin
      fails++;
      $display("FAIL timeout_idle: busy=%b writes=%0d, expected 0 0", busy, wr_cnt - w0);
    end
    exp_q.push_back(8'h4B);
    send_bytes(72'h48, 1);
    wait_idle(ok);
    tests++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_next: idle=%0d pending=%0d, expected idle=1 pending=0", ok, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_reply();
    bit ok, seen;
    ignore_tx = 1'b1;
    seen = 1'b0;
    send_bytes(72'h55, 1);
    for (int i = 0; i < 100 && !seen; i++) begin
      if (txd === 1'b0) seen = 1'b1;
      else @(negedge clk);
    end
    repeat (8) @(negedge clk);
    xreset = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (!seen || txd !== 1'b1 || hold !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: started=%0d txd=%b hold=%b busy=%b, expected 1 1 0 0", seen, txd, hold, busy);
    end
    @(negedge clk);
    xreset = 1'b1;
    repeat (60) @(negedge clk);
    ignore_tx = 1'b0;
    exp_q.push_back(8'h4B);
    send_bytes(72'h48, 1);
    wait_idle(ok);
    tests++;
    if (!ok || exp_q.size() != 0 || hold !== 1'b1) begin
      fails++;
      $display("FAIL after_reset: idle=%0d pending=%0d hold=%b, expected 1 0 1", ok, exp_q.size(), hold);
    end
  endtask

  initial begin
    test_reset();
    test_hold_go();
    test_write();
    test_read();
    test_stall();
    test_errors();
    test_timeout();
    test_reset_mid_reply();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
